fakeram7_req_ctrl: RTL and testbench

Valid/ready front-end for the single-port 256x32 fakeram7 SRAM macro. It accepts read/write requests from a client and drives the macro's `ce`/`we`/`addr`/`wd` pins directly. It captures the macro's 1-cycle read data and returns it on a valid/ready response port, buffered in a small FIFO so that client backpressure never loses data. It sits between the macro and any client logic, and is the only block allowed to toggle the macro's chip enable.

---
 rtl/fakeram7_req_ctrl.sv | 98 +++++++++
 tb/tb_fakeram7_req_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fakeram7_req_ctrl.sv
// Valid/ready request/response front-end for the single-port fakeram7 SRAM macro.
// Drives the macro pins directly and buffers 1-cycle read data in a small response FIFO.
module fakeram7_req_ctrl #(
  parameter int BITS       = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [BITS-1:0]       req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [BITS-1:0]       rsp_rdata_o,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [BITS-1:0]       ram_wd_o,
  input  logic [BITS-1:0]       ram_rd_i,
  output logic                  idle_o
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic                 r_reset_q;
  logic                 r_inflight;
  logic [CNT_W-1:0]     r_count;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [BITS-1:0]      r_fifo [RSP_DEPTH];

  logic [CNT_W:0]       w_used;
  logic                 w_accept;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits: every outstanding read (in flight or buffered) reserves one FIFO slot.
  assign w_used      = {1'b0, r_count} + (CNT_W + 1)'(r_inflight);
  assign req_ready_o = ~r_reset_q & (w_used < (CNT_W + 1)'(RSP_DEPTH));
  assign w_accept    = req_valid_i & req_ready_o;

  assign ram_ce_o    = w_accept;
  assign ram_we_o    = w_accept & req_we_i;
  assign ram_addr_o  = w_accept ? req_addr_i  : '0;
  assign ram_wd_o    = w_accept ? req_wdata_i : '0;

  assign w_empty     = (r_count == '0);
  assign rsp_valid_o = r_inflight | ~w_empty;
  assign w_push      = r_inflight & ~(w_empty & rsp_ready_i);
  assign w_pop       = ~w_empty & rsp_ready_i;
  assign idle_o      = ~r_inflight & w_empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rsp_rdata_o = '0;
    if (!w_empty) begin
      rsp_rdata_o = r_fifo[r_rd_ptr];
    end else if (r_inflight) begin
      rsp_rdata_o = ram_rd_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reset_q  <= 1'b1;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_reset_q  <= 1'b0;
      r_inflight <= w_accept & ~req_we_i;
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the count gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= ram_rd_i;
  end

endmodule

// File: tb/tb_fakeram7_req_ctrl.sv
// Self-checking bench for fakeram7_req_ctrl: macro model, transaction-level reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_fakeram7_req_ctrl;

  localparam int BITS       = 32;
  localparam int ADDR_WIDTH = 8;
  localparam int RSP_DEPTH  = 2;

  logic                  clk;
  logic                  reset;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [BITS-1:0]       req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [BITS-1:0]       rsp_rdata_o;
  logic                  ram_ce_o;
  logic                  ram_we_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [BITS-1:0]       ram_wd_o;
  logic [BITS-1:0]       ram_rd_i;
  logic                  idle_o;

  int n_tests = 0;
  int n_fail  = 0;

  fakeram7_req_ctrl #(
    .BITS       (BITS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .ram_ce_o    (ram_ce_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wd_o    (ram_wd_o),
    .ram_rd_i    (ram_rd_i),
    .idle_o      (idle_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Macro model: OR-merge writes, 1-cycle read data, garbage on every other cycle.
  logic [BITS-1:0] mac_mem [256];
  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o) begin
      mac_mem[ram_addr_o] <= mac_mem[ram_addr_o] | ram_wd_o;
      ram_rd_i            <= $urandom;
    end else if (ram_ce_o) begin
      ram_rd_i <= mac_mem[ram_addr_o];
    end else begin
      ram_rd_i <= $urandom;
    end
  end

  // Reference model: a queue of outstanding responses, credit-limited to RSP_DEPTH.
  logic [BITS-1:0] model_mem [256];
  logic [BITS-1:0] exp_q [$];
  bit              hold = 1'b1;

  always @(posedge clk or posedge reset) begin : model_upd
    bit rdy;
    bit acc;
    if (reset) begin
      exp_q.delete();
      hold = 1'b1;
    end else begin
      rdy = !hold && (exp_q.size() < RSP_DEPTH);
      acc = req_valid_i && rdy;
      if (exp_q.size() > 0 && rsp_ready_i) void'(exp_q.pop_front());
      if (acc) begin
        if (req_we_i) model_mem[req_addr_i] = model_mem[req_addr_i] | req_wdata_i;
        else          exp_q.push_back(model_mem[req_addr_i]);
      end
      hold = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    bit e_rdy;
    bit e_acc;
    e_rdy = !hold && (exp_q.size() < RSP_DEPTH);
    e_acc = req_valid_i && e_rdy;
    check("req_ready", 32'(req_ready_o), 32'(e_rdy));
    check("ram_ce",    32'(ram_ce_o),    32'(e_acc));
    check("ram_we",    32'(ram_we_o),    32'(e_acc && req_we_i));
    check("ram_addr",  32'(ram_addr_o),  e_acc ? 32'(req_addr_i) : 32'h0);
    check("ram_wd",    ram_wd_o,         e_acc ? req_wdata_i : 32'h0);
    check("rsp_valid", 32'(rsp_valid_o), 32'(exp_q.size() > 0));
    check("rsp_rdata", rsp_rdata_o,      (exp_q.size() > 0) ? exp_q[0] : 32'h0);
    check("idle",      32'(idle_o),      32'(exp_q.size() == 0));
  end

  task automatic set_req(input logic v, input logic we, input logic [7:0] a, input logic [31:0] wd);
    req_valid_i = v;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mac_mem[i]   = (i < 8) ? 32'(8'hA0 + i) : 32'h0;
      model_mem[i] = (i < 8) ? 32'(8'hA0 + i) : 32'h0;
    end
    reset       = 1'b0;
    rsp_ready_i = 1'b0;
    set_req(1'b0, 1'b0, 8'h00, 32'h0);

    // Reset values and the one-cycle post-reset ready hold-off.
    #2 reset = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready_o), 32'h0);
    check("rst_valid", 32'(rsp_valid_o), 32'h0);
    check("rst_idle",  32'(idle_o),      32'h1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 check("ready_hold", 32'(req_ready_o), 32'h0);
    tick();
    check("ready_up", 32'(req_ready_o), 32'h1);

    // Back-to-back reads of 0x00..0x07 with the client always ready.
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) set_req(1'b1, 1'b0, 8'(i), 32'h0);
      else       set_req(1'b0, 1'b0, 8'h00, 32'h0);
      #1;
      check("b2b_ce", 32'(ram_ce_o), 32'(i < 8));
      if (i > 0) begin
        check("b2b_valid", 32'(rsp_valid_o), 32'h1);
        check("b2b_data",  rsp_rdata_o,      32'(8'hA0 + i - 1));
      end
      tick();
    end
    check("b2b_idle", 32'(idle_o), 32'h1);

    // Backpressure: third read must wait for a credit.
    rsp_ready_i = 1'b0;
    set_req(1'b1, 1'b0, 8'h01, 32'h0);
    #1 check("bp_ce1", 32'(ram_ce_o), 32'h1);
    tick();
    set_req(1'b1, 1'b0, 8'h02, 32'h0);
    #1 check("bp_byp", rsp_rdata_o, 32'hA1);
    tick();
    set_req(1'b1, 1'b0, 8'h03, 32'h0);
    #1;
    check("bp_ready0", 32'(req_ready_o), 32'h0);
    check("bp_ce0",    32'(ram_ce_o),    32'h0);
    tick();
    check("bp_ce0b",   32'(ram_ce_o),    32'h0);
    tick();
    rsp_ready_i = 1'b1;
    #1;
    check("bp_d1",     rsp_rdata_o,      32'hA1);
    check("bp_ready1", 32'(req_ready_o), 32'h0);
    tick();
    check("bp_d2",     rsp_rdata_o,      32'hA2);
    check("bp_ce3",    32'(ram_ce_o),    32'h1);
    tick();
    set_req(1'b0, 1'b0, 8'h00, 32'h0);
    #1 check("bp_d3", rsp_rdata_o, 32'hA3);
    tick();
    check("bp_idle", 32'(idle_o), 32'h1);

    // Simultaneous push and pop with one entry buffered and one read in flight.
    rsp_ready_i = 1'b0;
    set_req(1'b1, 1'b0, 8'h04, 32'h0);
    tick();
    set_req(1'b1, 1'b0, 8'h06, 32'h0);
    #1 check("pp_ce", 32'(ram_ce_o), 32'h1);
    tick();
    set_req(1'b0, 1'b0, 8'h00, 32'h0);
    rsp_ready_i = 1'b1;
    #1;
    check("pp_d4",    rsp_rdata_o,      32'hA4);
    check("pp_full",  32'(req_ready_o), 32'h0);
    tick();
    check("pp_d6",    rsp_rdata_o,      32'hA6);
    check("pp_cnt1",  32'(req_ready_o), 32'h1);
    tick();
    check("pp_idle",  32'(idle_o),      32'h1);

    // Write 0xFFFF_FFFF to 0x05, then read it back.
    set_req(1'b1, 1'b1, 8'h05, 32'hFFFF_FFFF);
    #1;
    check("wr_ce",   32'(ram_ce_o),   32'h1);
    check("wr_we",   32'(ram_we_o),   32'h1);
    check("wr_addr", 32'(ram_addr_o), 32'h5);
    check("wr_wd",   ram_wd_o,        32'hFFFF_FFFF);
    tick();
    set_req(1'b1, 1'b0, 8'h05, 32'h0);
    #1;
    check("rd_we",    32'(ram_we_o),    32'h0);
    check("wr_norsp", 32'(rsp_valid_o), 32'h0);
    tick();
    set_req(1'b0, 1'b0, 8'h00, 32'h0);
    #1;
    check("rd_valid", 32'(rsp_valid_o), 32'h1);
    check("rd_data",  rsp_rdata_o,      32'hFFFF_FFFF);
    check("rd_ce0",   32'(ram_ce_o),    32'h0);
    tick();
    check("rd_idle",  32'(idle_o), 32'h1);

    // Reset mid-flight with a live request on the port.
    rsp_ready_i = 1'b0;
    set_req(1'b1, 1'b0, 8'h02, 32'h0);
    tick();
    set_req(1'b1, 1'b1, 8'h09, 32'h0000_0123);
    reset = 1'b1;
    #1;
    check("mr_ce",    32'(ram_ce_o),    32'h0);
    check("mr_we",    32'(ram_we_o),    32'h0);
    check("mr_addr",  32'(ram_addr_o),  32'h0);
    check("mr_wd",    ram_wd_o,         32'h0);
    check("mr_ready", 32'(req_ready_o), 32'h0);
    check("mr_valid", 32'(rsp_valid_o), 32'h0);
    check("mr_rdata", rsp_rdata_o,      32'h0);
    check("mr_idle",  32'(idle_o),      32'h1);
    tick();
    set_req(1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("mr_norsp", 32'(rsp_valid_o), 32'h0);
      tick();
    end
    check("mr_idle2", 32'(idle_o), 32'h1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
